nios_display_system_led_dimmer: RTL and testbench

NIOS_DISPLAY_SYSTEM_LED_DIMMER -- requirements
Module: nios_display_system_led_dimmer

---
 rtl/nios_display_system_led_dimmer_if.sv | 25 ++
 rtl/nios_display_system_led_dimmer.sv | 71 +++++++
 tb/tb_nios_display_system_led_dimmer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/nios_display_system_led_dimmer_if.sv
// Pin group between the LED/control PIOs and the LED dimmer.
// The PIO side is the master; the dimmer is the slave.
interface nios_display_system_led_dimmer_if;
    logic [9:0] pattern;
    logic [3:0] bright;
    logic       blink_en;
    logic [9:0] led;
    logic       frame_start;

    modport master (
        output pattern,
        output bright,
        output blink_en,
        input  led,
        input  frame_start
    );

    modport slave (
        input  pattern,
        input  bright,
        input  blink_en,
        output led,
        output frame_start
    );
endinterface

// File: rtl/nios_display_system_led_dimmer.sv
// 16-step PWM LED dimmer with optional blinking.
// The inputs are sampled only at frame boundaries, so they change without glitches.
module nios_display_system_led_dimmer #(
    parameter int unsigned PRESC_DIV    = 50,
    parameter int unsigned BLINK_FRAMES = 31250
) (
    input  logic                                 clk,
    input  logic                                 reset,
    nios_display_system_led_dimmer_if.slave      bus
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned LED_W = 10;
    localparam int unsigned BR_W  = 4;

    logic [CNT_W-1:0] presc;
    logic [BR_W-1:0]  pwm_cnt;
    logic [CNT_W-1:0] frame_cnt;
    logic             ph;
    logic [LED_W-1:0] pattern_s;
    logic [BR_W-1:0]  bright_s;
    logic             blink_en_s;
    logic [LED_W-1:0] led_q;
    logic             frame_start_q;

    logic tick_c;
    logic boundary_c;
    logic on_c;
    logic dark_c;

    assign tick_c     = (presc == CNT_W'(PRESC_DIV - 1));
    assign boundary_c = tick_c && (pwm_cnt == BR_W'(15));
    // Code 15 is fully on; any other code N gives N of 16 steps lit.
    assign on_c       = (bright_s == BR_W'(15)) || (pwm_cnt < bright_s);
    assign dark_c     = blink_en_s & ph;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc         <= '0;
            pwm_cnt       <= '0;
            frame_cnt     <= '0;
            ph            <= 1'b0;
            pattern_s     <= '0;
            bright_s      <= '0;
            blink_en_s    <= 1'b0;
            led_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            presc <= tick_c ? '0 : presc + CNT_W'(1);
            if (tick_c) begin
                pwm_cnt <= pwm_cnt + BR_W'(1);
            end
            // The shadows and the blink frame counter advance only at a frame boundary.
            if (boundary_c) begin
                pattern_s  <= bus.pattern;
                bright_s   <= bus.bright;
                blink_en_s <= bus.blink_en;
                if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    ph        <= ~ph;
                end else begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
            end
            led_q         <= pattern_s & {LED_W{on_c & ~dark_c}};
            frame_start_q <= boundary_c;
        end
    end

    assign bus.led         = led_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_nios_display_system_led_dimmer.sv
// Scoreboard bench for the LED dimmer: DUT0 uses PRESC_DIV=2 and BLINK_FRAMES=2.
// DUT1 uses PRESC_DIV=1 with a fixed dim single-LED input.
module tb_nios_display_system_led_dimmer;
    localparam int P0 = 2;
    localparam int P1 = 1;
    localparam int BF = 2;

    typedef struct packed {
        logic [9:0] led;
        logic       fs;
    } exp_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    nios_display_system_led_dimmer_if bus0 ();
    nios_display_system_led_dimmer_if bus1 ();

    nios_display_system_led_dimmer #(.PRESC_DIV(P0), .BLINK_FRAMES(BF)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    nios_display_system_led_dimmer #(.PRESC_DIV(P1), .BLINK_FRAMES(BF)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Closed-form model: clocks since reset give the step, frame and blink phase.
    int         n   [2];
    logic [9:0] shp [2];
    logic [3:0] shb [2];
    logic       she [2];
    exp_t       q0 [$];
    exp_t       q1 [$];

    task automatic step_model(input int i, input logic [9:0] pat, input logic [3:0] br,
                              input logic bl, output exp_t e);
        int   p, f, pos, stp, fc;
        logic ph, on;
        if (reset) begin
            n[i] = 0; shp[i] = '0; shb[i] = '0; she[i] = 1'b0; e = '0;
            return;
        end
        p   = (i == 0) ? P0 : P1;
        f   = 16 * p;
        pos = n[i] % f;
        stp = pos / p;
        fc  = n[i] / f;
        ph  = ((fc / BF) % 2) == 1;
        on  = (shb[i] == 4'd15) || (stp < int'(shb[i]));
        e.led = (on && !(she[i] && ph)) ? shp[i] : 10'h000;
        e.fs  = (pos == f - 1);
        if (e.fs) begin
            shp[i] = pat; shb[i] = br; she[i] = bl;
        end
        n[i]++;
    endtask

    always @(posedge clk) begin : predict
        exp_t e;
        step_model(0, bus0.pattern, bus0.bright, bus0.blink_en, e);
        q0.push_back(e);
        step_model(1, bus1.pattern, bus1.bright, bus1.blink_en, e);
        q1.push_back(e);
    end

    always @(negedge clk) begin : compare
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            if (reset) e = '0;
            check("led0", 32'(bus0.led), 32'(e.led));
            check("fs0", 32'(bus0.frame_start), 32'(e.fs));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            if (reset) e = '0;
            check("led1", 32'(bus1.led), 32'(e.led));
            check("fs1", 32'(bus1.frame_start), 32'(e.fs));
        end
    end

    task automatic wait_fs();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus0.frame_start) return;
        end
        check("fs_timeout", 32'(0), 32'(1));
    endtask

    task automatic drive(input logic [9:0] pat, input logic [3:0] br, input logic bl);
        bus0.pattern = pat; bus0.bright = br; bus0.blink_en = bl;
    endtask

    initial begin : stim
        int cnt;
        reset = 1'b1;
        drive(10'h000, 4'd0, 1'b0);
        bus1.pattern = 10'h001; bus1.bright = 4'd1; bus1.blink_en = 1'b0;
        repeat (5) @(negedge clk);
        drive(10'h3FF, 4'd8, 1'b0);
        reset = 1'b0;

        // Half duty, then the full-on and off extremes.
        repeat (4 * 32) @(negedge clk);
        drive(10'h155, 4'd15, 1'b0);
        repeat (2 * 32) @(negedge clk);
        drive(10'h155, 4'd0, 1'b0);
        repeat (2 * 32) @(negedge clk);

        // Change the pattern at step 7 of a frame.
        drive(10'h155, 4'd15, 1'b0);
        repeat (2 * 32) @(negedge clk);
        wait_fs();
        repeat (14) @(negedge clk);
        drive(10'h2AA, 4'd15, 1'b0);
        repeat (2 * 32) @(negedge clk);

        // Blink on, then blink off.
        drive(10'h3FF, 4'd15, 1'b1);
        repeat (8 * 32) @(negedge clk);
        drive(10'h3FF, 4'd15, 1'b0);
        repeat (4 * 32) @(negedge clk);

        // Mid-frame asynchronous reset.
        wait_fs();
        repeat (10) @(negedge clk);
        check("pre_rst_led", 32'(bus0.led), 32'h3FF);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_led_async", 32'(bus0.led), 32'h0);
        check("rst_fs_async", 32'(bus0.frame_start), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            cnt++;
            if (bus0.frame_start) break;
        end
        check("first_fs_delay", 32'(cnt), 32'd32);
        repeat (3 * 32) @(negedge clk);

        // Random input changes at random clocks.
        for (int k = 0; k < 640; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0)
                drive(10'($urandom), 4'($urandom), 1'($urandom));
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end
endmodule
